// File: rtl/custom_ip_regbank.sv
// custom_ip_regbank
//   Parametrised bridge between the register-file decoder and custom
//   hardware. Every channel is independent.
//
//   Write channels (NUM_WR) carry data from the register file to hardware.
//     reg2ip_valid_i / reg2ip_data_i / reg2ip_ready_o : request handshake
//     wr_data_o / wr_update_o                         : registered lane + 1-cycle strobe
//     hw_wr_done_i                                    : hardware releases the lane
//
//   Read channels (NUM_RD) are one-entry snapshot buffers from hardware.
//     hw_sample_i / hw_data_i                         : snapshot request + data
//     ip2reg_valid_o / ip2reg_data_o / ip2reg_ready_i : drain handshake
//     rd_overrun_o                                    : sticky overrun flag
//     clear_i                                         : clears all overrun flags
//
//   Clock clk_i; reset rst_ni is asynchronous and active-low.

// One write channel: IDLE accepts a request, BUSY blocks until released.
module custom_ip_regbank_wr_lane #(
  parameter int unsigned DATA_W       = 32,
  parameter bit          WR_AUTO_DONE = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_update_o,
  input  logic              hw_wr_done_i
);

  typedef enum logic {WR_IDLE, WR_BUSY} wr_state_e;

  wr_state_e state_q, state_d;
  logic      accept;

  assign accept  = valid_i && (state_q == WR_IDLE);
  // State is a flop, so ready is a registered output.
  assign ready_o = (state_q == WR_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE: if (valid_i) state_d = WR_BUSY;
      // Auto-done releases after exactly one BUSY cycle.
      WR_BUSY: if (WR_AUTO_DONE || hw_wr_done_i) state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WR_IDLE;
      wr_data_o   <= '0;
      wr_update_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_update_o <= accept;
      if (accept) wr_data_o <= data_i;
    end
  end

endmodule

// One read channel: single-entry snapshot buffer with sticky overrun.
module custom_ip_regbank_rd_lane #(
  parameter int unsigned       DATA_W       = 32,
  parameter bit                RD_OVERWRITE = 1'b1,
  parameter logic [DATA_W-1:0] RD_RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_i,
  input  logic [DATA_W-1:0] hw_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic              overrun_o,
  input  logic              clear_i
);

  typedef enum logic {RD_EMPTY, RD_FULL} rd_state_e;

  rd_state_e state_q, state_d;
  logic      capture;
  logic      ovr_set;
  logic      ovr_d;

  assign valid_o = (state_q == RD_FULL);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      RD_EMPTY: begin
        if (sample_i) begin
          state_d = RD_FULL;
          capture = 1'b1;
        end
      end
      RD_FULL: begin
        if (sample_i && ready_i) begin
          // Drain and refill in the same cycle: no data is lost.
          capture = 1'b1;
        end else if (ready_i) begin
          state_d = RD_EMPTY;
        end else if (sample_i) begin
          ovr_set = 1'b1;
          capture = RD_OVERWRITE;
        end
      end
      default: state_d = RD_EMPTY;
    endcase
    // A fresh overrun beats a coincident clear.
    ovr_d = ovr_set | (overrun_o & ~clear_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RD_EMPTY;
      data_o    <= RD_RESET_VAL;
      overrun_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_o <= ovr_d;
      if (capture) data_o <= hw_data_i;
    end
  end

endmodule

module custom_ip_regbank #(
  parameter int unsigned       NUM_WR       = 3,
  parameter int unsigned       NUM_RD       = 3,
  parameter int unsigned       DATA_W       = 32,
  parameter bit                WR_AUTO_DONE = 1'b0,
  parameter bit                RD_OVERWRITE = 1'b1,
  parameter logic [DATA_W-1:0] RD_RESET_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_WR-1:0]        reg2ip_valid_i,
  input  logic [NUM_WR*DATA_W-1:0] reg2ip_data_i,
  output logic [NUM_WR-1:0]        reg2ip_ready_o,
  output logic [NUM_WR*DATA_W-1:0] wr_data_o,
  output logic [NUM_WR-1:0]        wr_update_o,
  input  logic [NUM_WR-1:0]        hw_wr_done_i,
  input  logic [NUM_RD-1:0]        hw_sample_i,
  input  logic [NUM_RD*DATA_W-1:0] hw_data_i,
  output logic [NUM_RD-1:0]        ip2reg_valid_o,
  output logic [NUM_RD*DATA_W-1:0] ip2reg_data_o,
  input  logic [NUM_RD-1:0]        ip2reg_ready_i,
  output logic [NUM_RD-1:0]        rd_overrun_o,
  input  logic                     clear_i
);

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
    custom_ip_regbank_wr_lane #(
      .DATA_W       (DATA_W),
      .WR_AUTO_DONE (WR_AUTO_DONE)
    ) u_wr (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .valid_i      (reg2ip_valid_i[i]),
      .data_i       (reg2ip_data_i[i*DATA_W +: DATA_W]),
      .ready_o      (reg2ip_ready_o[i]),
      .wr_data_o    (wr_data_o[i*DATA_W +: DATA_W]),
      .wr_update_o  (wr_update_o[i]),
      .hw_wr_done_i (hw_wr_done_i[i])
    );
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    custom_ip_regbank_rd_lane #(
      .DATA_W       (DATA_W),
      .RD_OVERWRITE (RD_OVERWRITE),
      .RD_RESET_VAL (RD_RESET_VAL)
    ) u_rd (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .sample_i  (hw_sample_i[j]),
      .hw_data_i (hw_data_i[j*DATA_W +: DATA_W]),
      .valid_o   (ip2reg_valid_o[j]),
      .data_o    (ip2reg_data_o[j*DATA_W +: DATA_W]),
      .ready_i   (ip2reg_ready_i[j]),
      .overrun_o (rd_overrun_o[j]),
      .clear_i   (clear_i)
    );
  end

endmodule

// File: tb/tb_custom_ip_regbank.sv
// Directed bench for custom_ip_regbank. Two instances share the stimulus:
//   dut_a: WR_AUTO_DONE=0, RD_OVERWRITE=1
//   dut_b: WR_AUTO_DONE=1, RD_OVERWRITE=0
module tb_custom_ip_regbank;

  localparam int N = 3;
  localparam int W = 32;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   reg2ip_valid_i;
  logic [N*W-1:0] reg2ip_data_i;
  logic [N-1:0]   hw_wr_done_i;
  logic [N-1:0]   hw_sample_i;
  logic [N*W-1:0] hw_data_i;
  logic [N-1:0]   ip2reg_ready_i;
  logic           clear_i;

  logic [N-1:0]   a_ready, a_update, a_valid, a_ovr;
  logic [N*W-1:0] a_wr_data, a_rd_data;
  logic [N-1:0]   b_ready, b_update, b_valid, b_ovr;
  logic [N*W-1:0] b_wr_data, b_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  custom_ip_regbank #(
    .NUM_WR(N), .NUM_RD(N), .DATA_W(W), .WR_AUTO_DONE(1'b0), .RD_OVERWRITE(1'b1)
  ) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg2ip_valid_i(reg2ip_valid_i), .reg2ip_data_i(reg2ip_data_i),
    .reg2ip_ready_o(a_ready), .wr_data_o(a_wr_data), .wr_update_o(a_update),
    .hw_wr_done_i(hw_wr_done_i), .hw_sample_i(hw_sample_i), .hw_data_i(hw_data_i),
    .ip2reg_valid_o(a_valid), .ip2reg_data_o(a_rd_data), .ip2reg_ready_i(ip2reg_ready_i),
    .rd_overrun_o(a_ovr), .clear_i(clear_i)
  );

  custom_ip_regbank #(
    .NUM_WR(N), .NUM_RD(N), .DATA_W(W), .WR_AUTO_DONE(1'b1), .RD_OVERWRITE(1'b0)
  ) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg2ip_valid_i(reg2ip_valid_i), .reg2ip_data_i(reg2ip_data_i),
    .reg2ip_ready_o(b_ready), .wr_data_o(b_wr_data), .wr_update_o(b_update),
    .hw_wr_done_i(hw_wr_done_i), .hw_sample_i(hw_sample_i), .hw_data_i(hw_data_i),
    .ip2reg_valid_o(b_valid), .ip2reg_data_o(b_rd_data), .ip2reg_ready_i(ip2reg_ready_i),
    .rd_overrun_o(b_ovr), .clear_i(clear_i)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    reg2ip_valid_i = '0;
    reg2ip_data_i  = '0;
    hw_wr_done_i   = '0;
    hw_sample_i    = '0;
    hw_data_i      = '0;
    ip2reg_ready_i = '0;
    clear_i        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    checks++;
    if (a_ready !== 3'b111 || b_ready !== 3'b111) begin
      errors++; $display("FAIL reset_ready a=%b b=%b exp=111", a_ready, b_ready);
    end
    checks++;
    if (a_valid !== 3'b000 || a_ovr !== 3'b000 || a_update !== 3'b000) begin
      errors++; $display("FAIL reset_flags valid=%b ovr=%b upd=%b exp=000", a_valid, a_ovr, a_update);
    end
    checks++;
    if (a_rd_data !== '0 || a_wr_data !== '0) begin
      errors++; $display("FAIL reset_data rd=%h wr=%h exp=0", a_rd_data, a_wr_data);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_write_handshake();
    do_reset();
    reg2ip_valid_i = 3'b010;
    reg2ip_data_i[1*W +: W] = 32'h0000_2468;
    step();
    checks++;
    if (a_wr_data[1*W +: W] !== 32'h2468 || a_update !== 3'b010 || a_ready !== 3'b101) begin
      errors++; $display("FAIL wr_accept data=%h upd=%b rdy=%b exp=2468/010/101",
                         a_wr_data[1*W +: W], a_update, a_ready);
    end
    // Second request while BUSY must not be taken.
    reg2ip_data_i[1*W +: W] = 32'h0000_1111;
    step();
    checks++;
    if (a_wr_data[1*W +: W] !== 32'h2468 || a_update !== 3'b000 || a_ready !== 3'b101) begin
      errors++; $display("FAIL wr_busy_block data=%h upd=%b rdy=%b exp=2468/000/101",
                         a_wr_data[1*W +: W], a_update, a_ready);
    end
    reg2ip_valid_i = '0;
    step();
    checks++;
    if (a_ready !== 3'b101) begin
      errors++; $display("FAIL wr_wait_done rdy=%b exp=101", a_ready);
    end
    hw_wr_done_i = 3'b010;
    step();
    hw_wr_done_i = '0;
    checks++;
    if (a_ready !== 3'b111 || a_update !== 3'b000) begin
      errors++; $display("FAIL wr_release rdy=%b upd=%b exp=111/000", a_ready, a_update);
    end
  endtask

  task automatic test_auto_done();
    do_reset();
    reg2ip_valid_i = 3'b001;
    reg2ip_data_i[0 +: W] = 32'h1;
    step();
    checks++;
    if (b_update !== 3'b001 || b_wr_data[0 +: W] !== 32'h1 || b_ready[0] !== 1'b0) begin
      errors++; $display("FAIL auto_first upd=%b data=%h rdy0=%b exp=001/1/0",
                         b_update, b_wr_data[0 +: W], b_ready[0]);
    end
    reg2ip_data_i[0 +: W] = 32'h2;
    step();
    checks++;
    if (b_update !== 3'b000 || b_ready[0] !== 1'b1 || b_wr_data[0 +: W] !== 32'h1) begin
      errors++; $display("FAIL auto_gap upd=%b rdy0=%b data=%h exp=000/1/1",
                         b_update, b_ready[0], b_wr_data[0 +: W]);
    end
    step();
    checks++;
    if (b_update !== 3'b001 || b_wr_data[0 +: W] !== 32'h2) begin
      errors++; $display("FAIL auto_second upd=%b data=%h exp=001/2", b_update, b_wr_data[0 +: W]);
    end
    reg2ip_valid_i = '0;
    step();
    step();
    checks++;
    if (b_update !== 3'b000 || b_ready !== 3'b111 || b_wr_data[0 +: W] !== 32'h2) begin
      errors++; $display("FAIL auto_final upd=%b rdy=%b data=%h exp=000/111/2",
                         b_update, b_ready, b_wr_data[0 +: W]);
    end
  endtask

  task automatic test_read_drain();
    do_reset();
    hw_sample_i = 3'b100;
    hw_data_i[2*W +: W] = 32'h48D0;
    step();
    hw_sample_i = '0;
    checks++;
    if (a_valid !== 3'b100 || a_rd_data[2*W +: W] !== 32'h48D0) begin
      errors++; $display("FAIL rd_fill valid=%b data=%h exp=100/48d0", a_valid, a_rd_data[2*W +: W]);
    end
    ip2reg_ready_i = 3'b100;
    step();
    checks++;
    if (a_valid !== 3'b000 || a_rd_data[2*W +: W] !== 32'h48D0) begin
      errors++; $display("FAIL rd_drain valid=%b data=%h exp=000/48d0", a_valid, a_rd_data[2*W +: W]);
    end
    // Ready while EMPTY is ignored.
    step();
    ip2reg_ready_i = '0;
    checks++;
    if (a_valid !== 3'b000 || a_ovr !== 3'b000) begin
      errors++; $display("FAIL rd_empty_ready valid=%b ovr=%b exp=000/000", a_valid, a_ovr);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    hw_sample_i = 3'b001;
    hw_data_i[0 +: W] = 32'h369C;
    step();
    hw_data_i[0 +: W] = 32'hAAAA;
    step();
    hw_sample_i = '0;
    checks++;
    if (a_ovr !== 3'b001 || a_rd_data[0 +: W] !== 32'hAAAA || a_valid !== 3'b001) begin
      errors++; $display("FAIL ovr_overwrite ovr=%b data=%h valid=%b exp=001/aaaa/001",
                         a_ovr, a_rd_data[0 +: W], a_valid);
    end
    checks++;
    if (b_ovr !== 3'b001 || b_rd_data[0 +: W] !== 32'h369C) begin
      errors++; $display("FAIL ovr_keep ovr=%b data=%h exp=001/369c", b_ovr, b_rd_data[0 +: W]);
    end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if (a_ovr !== 3'b000 || b_ovr !== 3'b000) begin
      errors++; $display("FAIL ovr_clear a=%b b=%b exp=000", a_ovr, b_ovr);
    end
    hw_sample_i = 3'b001;
    hw_data_i[0 +: W] = 32'hBBBB;
    clear_i = 1'b1;
    step();
    hw_sample_i = '0;
    clear_i = 1'b0;
    checks++;
    if (a_ovr !== 3'b001 || b_ovr !== 3'b001) begin
      errors++; $display("FAIL ovr_clear_race a=%b b=%b exp=001", a_ovr, b_ovr);
    end
  endtask

  task automatic test_simul_ready_sample();
    do_reset();
    hw_sample_i = 3'b010;
    hw_data_i[1*W +: W] = 32'h1234;
    step();
    hw_data_i[1*W +: W] = 32'h5555;
    ip2reg_ready_i = 3'b010;
    step();
    hw_sample_i = '0;
    ip2reg_ready_i = '0;
    checks++;
    if (a_valid !== 3'b010 || a_rd_data[1*W +: W] !== 32'h5555 || a_ovr !== 3'b000) begin
      errors++; $display("FAIL rd_simul valid=%b data=%h ovr=%b exp=010/5555/000",
                         a_valid, a_rd_data[1*W +: W], a_ovr);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    reg2ip_valid_i = 3'b010;
    reg2ip_data_i[1*W +: W] = 32'h7777;
    step();
    reg2ip_valid_i = '0;
    step();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (a_ready !== 3'b111 || a_update !== 3'b000 || a_wr_data !== '0) begin
      errors++; $display("FAIL rst_mid_busy rdy=%b upd=%b wr=%h exp=111/000/0",
                         a_ready, a_update, a_wr_data);
    end
    step();
    rst_ni = 1'b1;
    step();
    checks++;
    if (a_ready !== 3'b111 || a_update !== 3'b000) begin
      errors++; $display("FAIL rst_after rdy=%b upd=%b exp=111/000", a_ready, a_update);
    end
  endtask

  initial begin
    test_reset();
    test_write_handshake();
    test_auto_done();
    test_read_drain();
    test_overrun();
    test_simul_ready_sample();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
